lms_update_sequencer: RTL

Sequences the LMS coefficient adaptation for the adaptive FIR. It accepts one error sample per filter output and compares its magnitude against the adaptation threshold. If adaptation is needed, it sweeps all taps once: it reads each coefficient and the matching input-history sample, then writes back a saturated Q1.15 update. It sits between the error-computation stage and the coefficient register bank / history buffer, and it is the only writer of the coefficient bank.

---
 rtl/params_pkg.sv | 34 +++
 rtl/lms_tap_update.sv | 30 +++
 rtl/lms_update_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared fixed-point types and LMS adaptation definitions for the adaptive FIR.
package params_pkg;

  localparam int TAP_COUNT         = 16;
  localparam int LEARNING_RATE_Q   = 164;
  localparam int ADAPT_THRESHOLD_Q = 1638;

  typedef logic signed [15:0] fxp_t;
  typedef logic signed [15:0] coeff_t;
  typedef logic signed [31:0] acc_t;
  typedef logic [$clog2(TAP_COUNT)-1:0] tap_idx_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MU_CALC = 3'd1,
    SWEEP   = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } lms_state_t;

  // Clamp a 17-bit signed sum into the Q1.15 coefficient range.
  function automatic coeff_t sat16(input logic signed [16:0] v);
    coeff_t r;
    if (v > 17'sh07FFF) begin
      r = 16'sh7FFF;
    end else if (v < 17'sh18000) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/lms_tap_update.sv
// Combinational per-tap LMS update: rounded mu_err*x delta, optional leak, Q1.15 saturation.
// Leakage is compiled in only when LMS_LEAKAGE_EN is defined.
module lms_tap_update
  import params_pkg::*;
#(
  parameter int LEAK_SHIFT = 10
) (
  input  logic signed [15:0] mu_err_i,
  input  logic signed [15:0] coef_i,
  input  logic signed [15:0] hist_i,
  output logic signed [15:0] new_coef_o
);

  acc_t               prod_s;
  logic signed [16:0] delta_s;
  logic signed [16:0] sum_s;

  // Rounded product, leak-adjusted sum and clamp for one tap.
  always_comb begin
    prod_s  = acc_t'(mu_err_i) * acc_t'(hist_i);
    delta_s = 17'((prod_s + 32'sd16384) >>> 15);
`ifdef LMS_LEAKAGE_EN
    sum_s   = 17'(coef_i) - 17'(coef_i >>> LEAK_SHIFT) + delta_s;
`else
    sum_s   = 17'(coef_i) + delta_s;
`endif
    new_coef_o = sat16(sum_s);
  end

endmodule

// File: rtl/lms_update_sequencer.sv
// LMS coefficient adaptation sequencer: threshold test, mu*err, one read/update/write sweep of all taps.
// Optional leakage on every written tap is enabled by defining LMS_LEAKAGE_EN.
module lms_update_sequencer
  import params_pkg::*;
#(
  parameter int TAP_COUNT  = params_pkg::TAP_COUNT,
  parameter int MU_Q       = LEARNING_RATE_Q,
  parameter int THRESH_Q   = ADAPT_THRESHOLD_Q,
  parameter int LEAK_SHIFT = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         err_valid,
  output logic                         err_ready,
  input  logic signed [15:0]           err_in,
  input  logic                         freeze,
  output logic [$clog2(TAP_COUNT)-1:0] rd_addr,
  input  logic signed [15:0]           coef_rd_data,
  input  logic signed [15:0]           hist_rd_data,
  output logic                         coef_wr_en,
  output logic [$clog2(TAP_COUNT)-1:0] coef_wr_addr,
  output logic signed [15:0]           coef_wr_data,
  output logic                         busy,
  output logic                         update_done,
  output logic                         skipped
);

  localparam int              IDX_W    = $clog2(TAP_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAP_COUNT - 1);

  lms_state_t         state_q, state_d;
  fxp_t               err_q, err_d;
  coeff_t             mu_err_q, mu_err_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic               skip_q, skip_d;
  logic               rd_vld_q;
  logic [IDX_W-1:0]   rd_idx_q;
  logic               wr_en_q;
  logic [IDX_W-1:0]   wr_addr_q;
  coeff_t             wr_data_q;

  fxp_t               abs_s;
  logic               adapt_s;
  coeff_t             mu_calc_s;
  coeff_t             new_coef_s;
  logic               accept_s;

  // The done_q term keeps err_ready low during the update_done cycle that follows IDLE entry.
  assign err_ready    = (state_q == IDLE) && !freeze && !done_q;
  assign accept_s     = err_valid && err_ready;
  assign busy         = ((state_q == MU_CALC) && adapt_s) || (state_q == SWEEP) ||
                        (state_q == DRAIN) || (state_q == DONE);
  assign rd_addr      = idx_q;
  assign coef_wr_en   = wr_en_q;
  assign coef_wr_addr = wr_addr_q;
  assign coef_wr_data = wr_data_q;
  assign update_done  = done_q;
  assign skipped      = skip_q;

  // Error magnitude with -32768 folded to 32767, threshold test and scaled step.
  always_comb begin
    if (err_q == 16'sh8000) begin
      abs_s = 16'sh7FFF;
    end else if (err_q[15]) begin
      abs_s = -err_q;
    end else begin
      abs_s = err_q;
    end
    adapt_s   = (abs_s >= fxp_t'(THRESH_Q));
    mu_calc_s = sat16(17'((acc_t'(MU_Q) * acc_t'(err_q) + 32'sd16384) >>> 15));
  end

  lms_tap_update #(
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_tap_update (
    .mu_err_i   (mu_err_q),
    .coef_i     (coef_rd_data),
    .hist_i     (hist_rd_data),
    .new_coef_o (new_coef_s)
  );

  // Next-state and control decode.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    mu_err_d = mu_err_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    skip_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          err_d   = err_in;
          state_d = MU_CALC;
        end else begin
          state_d = IDLE;
        end
      end
      MU_CALC: begin
        if (adapt_s) begin
          mu_err_d = mu_calc_s;
          idx_d    = '0;
          state_d  = SWEEP;
        end else begin
          done_d  = 1'b1;
          skip_d  = 1'b1;
          state_d = IDLE;
        end
      end
      SWEEP: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, sample registers and the read-to-write pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      err_q     <= 16'sd0;
      mu_err_q  <= 16'sd0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      skip_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 16'sd0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      mu_err_q  <= mu_err_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      skip_q    <= skip_d;
      rd_vld_q  <= (state_q == SWEEP);
      rd_idx_q  <= idx_q;
      wr_en_q   <= rd_vld_q;
      if (rd_vld_q) begin
        wr_addr_q <= rd_idx_q;
        wr_data_q <= new_coef_s;
      end
    end
  end

endmodule
